// File: rtl/vector_load_unit.sv
// Vector load stage: fetches LANES consecutive ROM words and publishes them as one vector.
// Optional bounds checking against SIZE is enabled by defining VLOAD_BOUNDS_CHECK_EN.
module vector_load_unit #(
  parameter int S    = 32,
  parameter int V    = 192,
  parameter int SIZE = 30000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] base_addr,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [V-1:0] vdata,
  output logic         mem_isVector,
  output logic [S-1:0] mem_addr,
  input  logic [S-1:0] mem_rd
);

  localparam int LANES = V / S;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  if (((V % S) != 0) || (SIZE < 1)) begin : g_bad_cfg
    $error("vector_load_unit: V must be a multiple of S and SIZE must be positive");
  end

  logic [1:0]    state_q, state_d;
  logic [S-1:0]  base_q, base_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [V-1:0]  shadow_q, shadow_d;
  logic [V-1:0]  vdata_q, vdata_d;
  logic          err_q, err_d;

  logic [S-1:0]  lane_addr;
  logic          oob;
  logic [S-1:0]  cap_word;
  logic          accept;

  // Address arithmetic wraps mod 2^S by construction.
  assign lane_addr = base_q + {{(S-LW){1'b0}}, lane_q};

`ifdef VLOAD_BOUNDS_CHECK_EN
  assign oob = (lane_addr >= S'(SIZE));
`else
  assign oob = 1'b0;
`endif

  assign cap_word     = oob ? '0 : mem_rd;
  assign mem_isVector = (state_q == ST_FETCH);
  assign mem_addr     = ((state_q == ST_FETCH) && !oob) ? lane_addr : '0;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign vdata        = vdata_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    lane_d   = lane_q;
    shadow_d = shadow_q;
    vdata_d  = vdata_q;
    err_d    = err_q;
    accept   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = start;
      end
      ST_FETCH: begin
        shadow_d[lane_q*S +: S] = cap_word;
        err_d = err_q | oob;
        if (lane_q == LAST_LANE) begin
          // Publish the whole vector on the edge that captures the last lane.
          vdata_d = shadow_d;
          lane_d  = '0;
          state_d = ST_DONE;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        accept  = start;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      base_d   = base_addr;
      lane_d   = '0;
      shadow_d = '0;
      err_d    = 1'b0;
      state_d  = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      lane_q   <= '0;
      shadow_q <= '0;
      vdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      lane_q   <= lane_d;
      shadow_q <= shadow_d;
      vdata_q  <= vdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/vector_load_unit.md
# vector_load_unit

Sequential vector load stage between the vector pipeline and the image data memory ROM. On a start request it reads `V/S` consecutive 32-bit words, one per cycle, from a base address. It drives the ROM's `isVector`/`address` inputs and samples its combinational `rd` output. It then presents the assembled 192-bit vector atomically to the vector register file write port.

## Interface
- `S`, default 32: scalar word width and address width.
- `V`, default 192: vector width; `LANES = V/S` (6); `V` must be an exact multiple of `S`.
- `SIZE`, default 30000: number of ROM words; used for bounds checking.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; sampled only in IDLE or DONE.
- `base_addr`  in  S  word address of lane 0; sampled with `start`.
- `busy`  out  1  high in FETCH and DONE.
- `done`  out  1  one-cycle pulse; `vdata` is valid from this cycle on.
- `err`  out  1  sticky out-of-range flag for the last load; cleared on accepted `start`.
- `vdata`  out  V  assembled vector; lane k is `vdata[k*S +: S]`.
- `mem_isVector`  out  1  to the ROM's `isVector` input.
- `mem_addr`  out  S  to the ROM's `address` input.
- `mem_rd`  in  S  from the ROM's `rd` output; combinational in `mem_addr`.

## Operation
- State machine: IDLE, FETCH, DONE.
- IDLE:
  - Outputs: `mem_isVector=0`, `mem_addr=0`.
  - `start=1` at an edge:
    - latch `base_addr` into `base_q`;
    - set `lane=0`;
    - clear `err` and the shadow buffer;
    - go to FETCH.
- FETCH:
  - Outputs: `mem_isVector=1`, `mem_addr = base_q + lane`. The sum is computed mod 2^S and wraps silently.
  - Each edge:
    - write `mem_rd` into shadow lane `lane`;
    - `lane++`.
  - After lane `LANES-1` is captured:
    - copy the shadow buffer to `vdata` in the same edge;
    - go to DONE.
  - `start` is ignored in FETCH.
- DONE:
  - Outputs: `done=1`, `mem_isVector=0`.
  - Next edge, `start=1`: behaves as the IDLE accept and goes to FETCH (back-to-back loads).
  - Next edge, `start=0`: go to IDLE.
- `vdata` changes only on the final FETCH edge. Between loads it holds its value, so partial vectors are never visible.
- `lane` counter width is `$clog2(LANES)`. It never exceeds `LANES-1`.
- Bounds: a lane address is out of range when `base_q + lane >= SIZE`. Handling depends on configuration; see below.

## Timing
- Reset values (asynchronous, immediate on `rst_n=0`):
  - state IDLE;
  - `busy=0`, `done=0`, `err=0`;
  - `vdata=0`, `mem_isVector=0`, `mem_addr=0`;
  - `lane=0`, shadow buffer 0.
- Latency: `start` sampled at edge E0. FETCH occupies cycles E0..E6 (6 lanes), `vdata` updates at E6, and `done` is high in cycle E6..E7.
- Throughput with back-to-back starts: one vector per `LANES+1` cycles.
- `busy` rises the cycle after `start` is accepted. It falls after DONE unless a new `start` is accepted there.
- Reset during FETCH: the load is abandoned, no `done` pulse, and `vdata` returns to 0.
- `start` together with `rst_n=0`: reset wins.

## Configuration
- Macro: `VLOAD_BOUNDS_CHECK_EN`.
- Defined:
  - An out-of-range lane writes 0 into its shadow slot instead of `mem_rd`.
  - `mem_addr` is forced to 0 for that lane.
  - `err` is set and stays high until the next accepted `start`.
- Undefined:
  - No comparison logic.
  - `mem_addr = base_q + lane` unconditionally and `mem_rd` is always captured.
  - `err` is tied to 0.

## Test plan
- Bench ROM model `rd = 32'h1000_0000 + address`, valid only while `isVector=1`.
- Reset, then idle: all outputs 0 while `rst_n=0` and after release with no `start`. `mem_isVector` stays 0 for 10 cycles.
- `start` with `base_addr=100`: `mem_addr` reads 100..105 on consecutive cycles. `done` pulses in exactly one cycle, 6 cycles after acceptance. `vdata = {0x1000_0069, …, 0x1000_0064}`, lane 0 at LSBs.
- Back-to-back loads: `start` with base 0, then `start` held in the DONE cycle with base 6. Second `done` arrives 7 cycles after the first. `vdata` lane 0 becomes `0x1000_0006`.
- `start` pulses during FETCH: ignored. No extra `done`, and `base_q` is unchanged.
- Bounds check with the macro defined, `base_addr=29997`: lanes 0–2 are `0x1000_752D`..`0x1000_752F`, lanes 3–5 are 0, and `err=1`. Without the macro, lanes 3–5 are the model's values for 30000..30002 and `err=0`.
- `rst_n` pulled low at the third FETCH cycle: immediate IDLE, `vdata=0`, no `done`. A new `start` after release completes normally.
